// File: rtl/vic_irq_controller_if.sv
// CPU-side configuration and interrupt handshake bundle for vic_irq_controller.
// The controller takes the slave modport; the CPU/config agent drives the master side.
interface vic_irq_controller_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cpu_ack;
  logic        cpu_eoi;
  logic        irq_valid;
  logic [3:0]  irq_handler_num;
  logic        irq_is_nv;
  logic [15:0] in_service;
  logic        nv_in_service;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cpu_ack, cpu_eoi,
    input  irq_valid, irq_handler_num, irq_is_nv, in_service, nv_in_service
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cpu_ack, cpu_eoi,
    output irq_valid, irq_handler_num, irq_is_nv, in_service, nv_in_service
  );
endinterface

// File: rtl/vic_irq_controller.sv
// Vectored interrupt controller: 16 prioritised vectored sources plus one non-vectored
// source, valid/ack presentation to the CPU and in-service nesting tracked until EOI.
module vic_irq_controller #(
  parameter int unsigned NUM_VIRQ = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_VIRQ-1:0] vIRQRaw,
  input  logic                nvIRQRaw,
  vic_irq_controller_if.slave bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t      state_q, state_d;
  logic [15:0] enable_q, edge_q, pend_q, isr_q, prev_q;
  logic [15:0] pend_d, isr_d;
  logic        nv_is_q, nv_is_d;
  logic [3:0]  num_q, num_d;
  logic        nv_q, nv_d;

  logic [15:0] set_mask, clr_mask, rise, lowbit, below_t, elig, ack_vec, eoi_clr;
  logic [3:0]  sel;
  logic        found, nv_elig, cur_elig, ack_take;

  assign set_mask = (bus.cfg_we && bus.cfg_addr == 2'd2) ? bus.cfg_wdata : '0;
  assign clr_mask = (bus.cfg_we && bus.cfg_addr == 2'd3) ? bus.cfg_wdata : '0;
  assign rise     = vIRQRaw & ~prev_q;

  // Threshold mask: every index strictly below the lowest in-service bit.
  assign lowbit   = isr_q & (~isr_q + 16'd1);
  assign below_t  = (isr_q == '0) ? '1 : (lowbit - 16'd1);
  assign elig     = pend_q & enable_q & below_t;
  assign nv_elig  = nvIRQRaw && (isr_q == '0) && !nv_is_q && (elig == '0);
  assign cur_elig = nv_q ? nv_elig : elig[num_q];

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (elig[i] && !found) begin
        sel   = i[3:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    nv_d     = nv_q;
    ack_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          num_d   = sel;
          nv_d    = 1'b0;
          state_d = PRESENT;
        end else if (nv_elig) begin
          num_d   = '0;
          nv_d    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (!cur_elig) begin
          state_d = IDLE;
        end else if (bus.cpu_ack) begin
          ack_take = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack_vec = (ack_take && !nv_q) ? (16'd1 << num_q) : '0;
  assign eoi_clr = bus.cpu_eoi ? lowbit : '0;

  // Edge bits: clear/ack-clear first, then a new edge or set-pending wins.
  // Level bits: follow the raw line, with clear/set applied for this cycle only.
  assign pend_d = (edge_q & ((pend_q & ~clr_mask & ~ack_vec) | rise | set_mask)) |
                  (~edge_q & ((vIRQRaw & ~clr_mask) | set_mask));

  // EOI clear is applied before the ack set so both may land in one cycle.
  assign isr_d   = (isr_q & ~eoi_clr) | ack_vec;
  assign nv_is_d = (nv_is_q && !(bus.cpu_eoi && isr_q == '0)) || (ack_take && nv_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      enable_q <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      isr_q    <= '0;
      prev_q   <= '0;
      nv_is_q  <= 1'b0;
      num_q    <= '0;
      nv_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      isr_q   <= isr_d;
      prev_q  <= vIRQRaw;
      nv_is_q <= nv_is_d;
      num_q   <= num_d;
      nv_q    <= nv_d;
      if (bus.cfg_we && bus.cfg_addr == 2'd0) enable_q <= bus.cfg_wdata;
      if (bus.cfg_we && bus.cfg_addr == 2'd1) edge_q   <= bus.cfg_wdata;
    end
  end

  assign bus.irq_valid       = (state_q == PRESENT);
  assign bus.irq_handler_num = num_q;
  assign bus.irq_is_nv       = nv_q;
  assign bus.in_service      = isr_q;
  assign bus.nv_in_service   = nv_is_q;

endmodule

// File: doc/vic_irq_controller.md
Name: vic_irq_controller

Overview:
Sequencing controller for the vectored interrupt path. It captures 16 vectored sources and 1 non-vectored source, applies enable and edge/level configuration, and selects one request by fixed priority (index 0 highest, non-vectored lowest). It presents the selected request to the CPU through a valid/ack handshake and tracks in-service nesting until end-of-interrupt. It sits between the peripheral IRQ lines and the core's exception entry logic.

Parameters:
NUM_VIRQ, 16, number of vectored sources; fixed at 16 for this revision, and the handler number is 4 bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
vIRQRaw  input  16  raw vectored source lines
nvIRQRaw  input  1  raw non-vectored line, level-sensitive
cfg_we  input  1  configuration write strobe
cfg_addr  input  2  0=enable, 1=edge-select (1=edge, 0=level), 2=set-pending, 3=clear-pending
cfg_wdata  input  16  configuration write data
cpu_ack  input  1  CPU accepts the presented interrupt
cpu_eoi  input  1  CPU signals end of the current handler
irq_valid  output  1  interrupt presented to CPU
irq_handler_num  output  4  vector index of the presented request
irq_is_nv  output  1  presented request is non-vectored
in_service  output  16  in-service bitmask (ISR)
nv_in_service  output  1  non-vectored handler active

Behaviour:
- Reset values: enable, edge-select, pending, ISR, previous-sample register, nv_in_service, irq_valid, irq_handler_num and irq_is_nv all 0. FSM goes to IDLE. Reset mid-handshake drops irq_valid on the next edge and loses all pending requests.
- Pending, edge sources: bit set on a 0->1 transition of vIRQRaw against the previous-cycle sample. Pending, level sources: pending tracks vIRQRaw directly, and a set-pending write ORs in for one cycle only.
- Config writes take effect at the edge. Set-pending ORs cfg_wdata into pending. Clear-pending clears the written bits. If a set and a clear hit the same bit in the same cycle, the set wins.
- Threshold T = index of the lowest set ISR bit; T = 16 if ISR = 0.
- Eligible vectored = pending & enable & (bits with index < T). Selection is the lowest eligible index.
- Non-vectored is eligible only when nvIRQRaw=1, ISR=0, nv_in_service=0 and no vectored source is eligible.
- FSM IDLE: if any source is eligible, register the selection into irq_handler_num/irq_is_nv, set irq_valid=1 and go to PRESENT. Otherwise outputs hold, with irq_valid=0.
- FSM PRESENT: irq_valid stays 1 and irq_handler_num/irq_is_nv stay stable; no re-arbitration happens here.
  - On cpu_ack=1:
    - Vectored: set ISR bit, clear the pending bit if the source is edge-type.
    - Non-vectored: set nv_in_service.
    - In both cases go to IDLE with irq_valid=0.
  - If the presented source stops being eligible before ack (cleared, disabled, or a level line dropped), go to IDLE with irq_valid=0; no ISR change.
  - A new edge on the same source in the ack cycle re-sets pending (set wins over ack-clear).
- Latency: a raw edge at edge N sets pending at N; irq_valid is high after edge N+1. The minimum ack-to-next-present gap is 1 cycle in IDLE.
- Nesting: a source with a lower index than T preempts. Its request is presented while a lower-priority handler is in service.
- cpu_eoi clears the lowest set ISR bit. If ISR = 0, it clears nv_in_service instead. If both are 0, eoi is ignored.
- When eoi and ack arrive in the same cycle, the eoi clear is applied first, then the ack set.
- cpu_ack while irq_valid=0 is ignored.

Test Plan:
- Edge capture: enable=0x0001, edge=0x0001, pulse vIRQRaw[0] for 1 cycle -> irq_valid=1 two edges later, handler=0, irq_is_nv=0; ack -> in_service=0x0001, pending[0]=0.
- Priority: enable=0xFFFF, level, vIRQRaw=0x8010 -> handler=4; ack; eoi; then handler=15 is presented.
- Preemption: ISR=0x0020 (source 5 active), assert source 2 -> presented handler=2; assert source 9 -> not presented until both eoi's complete; after the first eoi ISR=0x0020, after the second ISR=0x0000.
- Non-vectored: vIRQRaw=0, nvIRQRaw=1 -> irq_is_nv=1, handler=0; ack -> nv_in_service=1; eoi -> 0. With vIRQRaw[3]=1 enabled, nv is never presented.
- Withdrawal: present source 7, write clear-pending 0x0080 before ack -> irq_valid=0 next edge, ISR unchanged.
- Reset mid-operation: irq_valid=1, ISR=0x0003, assert rst one cycle -> all outputs 0, pending cleared, no stale request re-presented.
